// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and constants for the hazard scoreboard: register-select type,
// scoreboard entry layout and the register-file forwarding select.
package hazard_scoreboard_pkg;

  localparam int SB_REG_W = 5;
  localparam int FWD_RF   = 0;

  typedef logic [SB_REG_W-1:0] regbits_t;

  typedef struct packed {
    logic     v;
    regbits_t wsel;
    logic     load;
  } sb_entry_t;

  // Width of a forwarding select able to name the register file plus every stage.
  function automatic int fs_width(input int stages);
    return $clog2(stages + 1);
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode-side bundle between the control unit / pipeline control and the
// hazard scoreboard.
interface hazard_scoreboard_if
  import hazard_scoreboard_pkg::*;
#(
  parameter int NUM_SRC = 2,
  parameter int REG_W   = SB_REG_W,
  parameter int STAGES  = 3
);

  localparam int FS_W = fs_width(STAGES);

  logic                             issue_valid;
  logic                             issue_wen;
  logic [REG_W-1:0]                 issue_wsel;
  logic                             issue_load;
  logic [NUM_SRC-1:0]               src_valid;
  logic [NUM_SRC-1:0][REG_W-1:0]    src_sel;
  logic                             advance;
  logic                             flush;
  logic                             stall;
  logic [NUM_SRC-1:0][FS_W-1:0]     fwd_sel;
  logic [31:0]                      stall_cycles;

  modport master (
    output issue_valid, issue_wen, issue_wsel, issue_load,
    output src_valid, src_sel, advance, flush,
    input  stall, fwd_sel, stall_cycles
  );

  modport slave (
    input  issue_valid, issue_wen, issue_wsel, issue_load,
    input  src_valid, src_sel, advance, flush,
    output stall, fwd_sel, stall_cycles
  );

endinterface

// File: rtl/hazard_scoreboard_hazard_match.sv
// Youngest-writer priority finder for one source operand; turns the match
// position into either a hazard or a forwarding select.
module hazard_match
  import hazard_scoreboard_pkg::*;
#(
  parameter int STAGES     = 3,
  parameter int REG_W      = SB_REG_W,
  parameter int FWD_EN     = 1,
  parameter int LOAD_READY = 2,
  parameter int FS_W       = fs_width(STAGES)
) (
  input  logic                         chk_i,
  input  logic [REG_W-1:0]             sel_i,
  input  logic [STAGES-1:0]            v_i,
  input  logic [STAGES-1:0][REG_W-1:0] wsel_i,
  input  logic [STAGES-1:0]            load_i,
  output logic                         hazard_o,
  output logic [FS_W-1:0]              fwd_sel_o
);

  logic hit;
  logic hit_ld;
  int   hit_k;

  always_comb begin
    hit    = 1'b0;
    hit_ld = 1'b0;
    hit_k  = 0;
    // Scan oldest to youngest so the youngest match overwrites older ones.
    for (int k = STAGES; k >= 1; k--) begin
      if (chk_i && v_i[k-1] && (wsel_i[k-1] == sel_i)) begin
        hit    = 1'b1;
        hit_ld = load_i[k-1];
        hit_k  = k;
      end
    end

    hazard_o  = 1'b0;
    fwd_sel_o = FS_W'(FWD_RF);
    if (hit) begin
      if (FWD_EN != 0) begin
        if (hit_ld && (hit_k < LOAD_READY)) hazard_o = 1'b1;
        else                                fwd_sel_o = FS_W'(hit_k);
      end else if (hit_k < STAGES) begin
        hazard_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Scoreboard of in-flight register writers that shifts with the pipeline and
// yields the decode stall, per-operand forwarding selects and a stall counter.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int STAGES     = 3,
  parameter int NUM_SRC    = 2,
  parameter int REG_W      = SB_REG_W,
  parameter int FWD_EN     = 1,
  parameter int LOAD_READY = 2
) (
  input  logic                CLK,
  input  logic                nRST,
  hazard_scoreboard_if.slave  bus
);

  localparam int FS_W = fs_width(STAGES);

  logic [STAGES-1:0]            v_q, v_d;
  logic [STAGES-1:0]            ld_q, ld_d;
  logic [STAGES-1:0][REG_W-1:0] ws_q, ws_d;
  logic [31:0]                  cnt_q, cnt_d;
  logic [NUM_SRC-1:0]           haz;
  logic                         stall;
  logic                         issue_rec;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    hazard_match #(
      .STAGES    (STAGES),
      .REG_W     (REG_W),
      .FWD_EN    (FWD_EN),
      .LOAD_READY(LOAD_READY),
      .FS_W      (FS_W)
    ) u_match (
      .chk_i    (bus.issue_valid & bus.src_valid[i] & (bus.src_sel[i] != '0)),
      .sel_i    (bus.src_sel[i]),
      .v_i      (v_q),
      .wsel_i   (ws_q),
      .load_i   (ld_q),
      .hazard_o (haz[i]),
      .fwd_sel_o(bus.fwd_sel[i])
    );
  end

  assign stall            = |haz;
  assign bus.stall        = stall;
  assign bus.stall_cycles = cnt_q;

  // A stalled or squashed decode slot enters EX as a bubble.
  assign issue_rec = bus.issue_valid & bus.issue_wen & (bus.issue_wsel != '0)
                   & ~stall & ~bus.flush;

  always_comb begin
    v_d  = v_q;
    ws_d = ws_q;
    ld_d = ld_q;
    if (bus.advance) begin
      v_d  = {v_q[STAGES-2:0], issue_rec};
      ws_d = {ws_q[STAGES-2:0], bus.issue_wsel};
      ld_d = {ld_q[STAGES-2:0], bus.issue_load};
    end
    cnt_d = (stall && (cnt_q != '1)) ? cnt_q + 32'd1 : cnt_q;
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      v_q   <= '0;
      cnt_q <= '0;
    end else begin
      v_q   <= v_d;
      cnt_q <= cnt_d;
    end
  end

  // Payload fields are meaningless while v is clear, so they carry no reset.
  always_ff @(posedge CLK) begin
    ws_q <= ws_d;
    ld_q <= ld_d;
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Drives a forwarding instance and a stall-only instance with identical decode
// streams and compares both against a queue-based reference of in-flight writers.
module tb_hazard_scoreboard;

  localparam int STG = 3;
  localparam int LRDY = 2;

  logic CLK = 1'b0;
  logic nRST;
  always #5 CLK = ~CLK;

  logic       iv, wen, ld, adv, fl;
  logic [4:0] ws, s0, s1;
  logic [1:0] sv;

  hazard_scoreboard_if #(.NUM_SRC(2), .REG_W(5), .STAGES(STG)) bf ();
  hazard_scoreboard_if #(.NUM_SRC(2), .REG_W(5), .STAGES(STG)) bs ();

  assign bf.issue_valid = iv;  assign bs.issue_valid = iv;
  assign bf.issue_wen   = wen; assign bs.issue_wen   = wen;
  assign bf.issue_wsel  = ws;  assign bs.issue_wsel  = ws;
  assign bf.issue_load  = ld;  assign bs.issue_load  = ld;
  assign bf.src_valid   = sv;  assign bs.src_valid   = sv;
  assign bf.src_sel     = {s1, s0};
  assign bs.src_sel     = {s1, s0};
  assign bf.advance     = adv; assign bs.advance     = adv;
  assign bf.flush       = fl;  assign bs.flush       = fl;

  hazard_scoreboard #(.STAGES(STG), .NUM_SRC(2), .REG_W(5), .FWD_EN(1), .LOAD_READY(LRDY))
    dut_f (.CLK(CLK), .nRST(nRST), .bus(bf));
  hazard_scoreboard #(.STAGES(STG), .NUM_SRC(2), .REG_W(5), .FWD_EN(0), .LOAD_READY(LRDY))
    dut_s (.CLK(CLK), .nRST(nRST), .bus(bs));

  typedef struct {
    bit         v;
    logic [4:0] r;
    bit         ld;
  } wr_t;

  wr_t         qf[$];
  wr_t         qs[$];
  logic [31:0] cf, cs;
  bit          stf, sts;
  bit          chk_on;
  int          n_cmp, n_err;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference: the writer list, youngest first; decide per operand from the rules.
  function automatic void meval(input wr_t q[$], input bit fe,
                                output bit st, output int f0, output int f1);
    int ss[2];
    int fs[2];
    ss[0] = int'(s0);
    ss[1] = int'(s1);
    st = 1'b0;
    for (int i = 0; i < 2; i++) begin
      int hk;
      fs[i] = 0;
      hk = 0;
      if (iv && sv[i] && ss[i] != 0) begin
        for (int k = 1; k <= q.size(); k++) begin
          if (q[k-1].v && int'(q[k-1].r) == ss[i]) begin
            hk = k;
            break;
          end
        end
      end
      if (hk != 0) begin
        if (fe) begin
          if (q[hk-1].ld && hk < LRDY) st = 1'b1;
          else                         fs[i] = hk;
        end else if (hk < STG) begin
          st = 1'b1;
        end
      end
    end
    f0 = fs[0];
    f1 = fs[1];
  endfunction

  task automatic mcheck();
    int f0, f1;
    meval(qf, 1'b1, stf, f0, f1);
    check("f_stall", 32'(bf.stall), 32'(stf));
    check("f_fwd0", 32'(bf.fwd_sel[0]), 32'(f0));
    check("f_fwd1", 32'(bf.fwd_sel[1]), 32'(f1));
    check("f_cnt", bf.stall_cycles, cf);
    meval(qs, 1'b0, sts, f0, f1);
    check("s_stall", 32'(bs.stall), 32'(sts));
    check("s_fwd0", 32'(bs.fwd_sel[0]), 32'(f0));
    check("s_fwd1", 32'(bs.fwd_sel[1]), 32'(f1));
    check("s_cnt", bs.stall_cycles, cs);
  endtask

  task automatic mupdate();
    if (!nRST) begin
      qf.delete(); qs.delete();
      cf = 0; cs = 0;
    end else begin
      if (stf && cf != 32'hFFFF_FFFF) cf++;
      if (sts && cs != 32'hFFFF_FFFF) cs++;
      if (adv) begin
        qf.push_front('{iv && wen && ws != 0 && !stf && !fl, ws, ld});
        qs.push_front('{iv && wen && ws != 0 && !sts && !fl, ws, ld});
        if (qf.size() > STG) void'(qf.pop_back());
        if (qs.size() > STG) void'(qs.pop_back());
      end
    end
  endtask

  // Called at a falling edge: check, cross the rising edge, then settle.
  task automatic finish_cycle();
    if (chk_on) mcheck();
    else begin stf = 1'b0; sts = 1'b0; end
    @(posedge CLK);
    mupdate();
    #1;
  endtask

  task automatic tick();
    @(negedge CLK);
    finish_cycle();
  endtask

  task automatic drive(input bit v, input bit we, input logic [4:0] w, input bit l,
                       input logic [1:0] s, input logic [4:0] a0, input logic [4:0] a1,
                       input bit a, input bit f);
    iv = v; wen = we; ws = w; ld = l; sv = s; s0 = a0; s1 = a1; adv = a; fl = f;
  endtask

  task automatic reset_tick();
    nRST = 1'b0;
    drive(0, 0, 5'd0, 0, 2'b00, 5'd0, 5'd0, 1, 0);
    tick();
    nRST = 1'b1;
  endtask

  initial begin
    n_cmp = 0; n_err = 0; chk_on = 1'b0;
    cf = 0; cs = 0;
    // Reset held two cycles with a matching consumer on decode.
    nRST = 1'b0;
    drive(1, 1, 5'd5, 0, 2'b11, 5'd5, 5'd5, 1, 0);
    tick();
    tick();
    nRST = 1'b1;
    chk_on = 1'b1;
    @(negedge CLK);
    check("rst_stall", 32'(bf.stall), 32'd0);
    check("rst_fwd0", 32'(bf.fwd_sel[0]), 32'd0);
    check("rst_cnt", bf.stall_cycles, 32'd0);
    finish_cycle();

    // ALU back-to-back
    reset_tick();
    drive(1, 1, 5'd5, 0, 2'b00, 5'd0, 5'd0, 1, 0); tick();
    drive(1, 0, 5'd0, 0, 2'b01, 5'd5, 5'd0, 1, 0);
    @(negedge CLK);
    check("alu_f_fwd1", 32'(bf.fwd_sel[0]), 32'd1);
    check("alu_f_nostall", 32'(bf.stall), 32'd0);
    check("so_stall_a", 32'(bs.stall), 32'd1);
    finish_cycle();
    @(negedge CLK);
    check("alu_f_fwd2", 32'(bf.fwd_sel[0]), 32'd2);
    check("so_stall_b", 32'(bs.stall), 32'd1);
    finish_cycle();
    @(negedge CLK);
    check("alu_f_fwd3", 32'(bf.fwd_sel[0]), 32'd3);
    check("so_release", 32'(bs.stall), 32'd0);
    check("so_fwd0", 32'(bs.fwd_sel[0]), 32'd0);
    finish_cycle();

    // Load-use
    reset_tick();
    drive(1, 1, 5'd8, 1, 2'b00, 5'd0, 5'd0, 1, 0); tick();
    drive(1, 0, 5'd0, 0, 2'b10, 5'd0, 5'd8, 1, 0);
    @(negedge CLK);
    check("lu_stall", 32'(bf.stall), 32'd1);
    finish_cycle();
    @(negedge CLK);
    check("lu_release", 32'(bf.stall), 32'd0);
    check("lu_fwd", 32'(bf.fwd_sel[1]), 32'd2);
    check("lu_cnt", bf.stall_cycles, 32'd1);
    check("lu_s_cnt", bs.stall_cycles, 32'd1);
    finish_cycle();

    // Register 0 never matches; youngest writer wins
    reset_tick();
    drive(1, 1, 5'd0, 0, 2'b00, 5'd0, 5'd0, 1, 0); tick();
    drive(1, 1, 5'd4, 0, 2'b00, 5'd0, 5'd0, 1, 0); tick();
    drive(1, 1, 5'd4, 0, 2'b00, 5'd0, 5'd0, 1, 0); tick();
    drive(1, 0, 5'd0, 0, 2'b11, 5'd4, 5'd0, 0, 0);
    @(negedge CLK);
    check("young_fwd", 32'(bf.fwd_sel[0]), 32'd1);
    check("zero_fwd", 32'(bf.fwd_sel[1]), 32'd0);
    finish_cycle();

    // Freeze with a pending load hazard
    reset_tick();
    drive(1, 1, 5'd8, 1, 2'b00, 5'd0, 5'd0, 1, 0); tick();
    drive(1, 0, 5'd0, 0, 2'b10, 5'd0, 5'd8, 0, 0);
    repeat (5) tick();
    @(negedge CLK);
    check("frz_stall", 32'(bf.stall), 32'd1);
    check("frz_cnt", bf.stall_cycles, 32'd5);
    finish_cycle();
    adv = 1'b1; tick();
    @(negedge CLK);
    check("frz_fwd", 32'(bf.fwd_sel[1]), 32'd2);
    finish_cycle();

    // Flushed writer enters as a bubble
    reset_tick();
    drive(1, 1, 5'd6, 0, 2'b00, 5'd0, 5'd0, 1, 1); tick();
    drive(1, 0, 5'd0, 0, 2'b01, 5'd6, 5'd0, 1, 0);
    @(negedge CLK);
    check("fl_fwd", 32'(bf.fwd_sel[0]), 32'd0);
    check("fl_f_stall", 32'(bf.stall), 32'd0);
    check("fl_s_stall", 32'(bs.stall), 32'd0);
    finish_cycle();

    // Randomized traffic over a small register window to provoke matches
    for (int n = 0; n < 3000; n++) begin
      nRST = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
      drive($urandom_range(0, 9) < 8, $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)),
            $urandom_range(0, 2) == 0, 2'($urandom_range(0, 3)),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
